// File: rtl/color_mapper_pipe.sv
// -----------------------------------------------------------------------------
// color_mapper_pipe
//
// Three-register colour pipeline between the VGA timing generator and the DAC.
// It turns a screen coordinate into a 320x240 frame-buffer read, maps the 4-bit
// pixel index through a 16-entry palette, and overlays a single square sprite
// of a fixed colour. The sync and blank inputs travel through three plain
// registers, so they stay aligned with the colour they belong to.
//
// Ports
//   VGA_CLK                  pixel clock; every register updates on its rising edge
//   Reset                    synchronous, active-high
//   DrawX, DrawY             current pixel coordinate from the timing generator
//   HS_in, VS_in, BLANK_N_in sync/blank, aligned with DrawX/DrawY
//   sprite_x, sprite_y       requested sprite top-left corner (screen pixels)
//   pal_we, pal_idx,
//   pal_data                 palette write port
//   fb_addr                  frame-buffer read address (registered, stage 1)
//   fb_rdata                 frame-buffer data for fb_addr, sampled on the
//                            edge after fb_addr is registered
//   VGA_R, VGA_G, VGA_B      colour outputs (stage 3)
//   VGA_HS, VGA_VS,
//   VGA_BLANK_N              sync/blank delayed by three registers
//   frame_start              one-cycle pulse after the edge that sees (0,0)
//   frame_count              number of frame_start pulses, modulo 256
//
// Timing: a coordinate sampled on edge 1 yields fb_addr after edge 1, the pixel
// index is captured on edge 2, and the colour is on VGA_R/G/B after edge 3.
// -----------------------------------------------------------------------------
module color_mapper_pipe #(
  parameter int          SPRITE_SIZE  = 16,
  parameter logic [23:0] SPRITE_COLOR = 24'hFF0000
) (
  input  logic        VGA_CLK,
  input  logic        Reset,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        HS_in,
  input  logic        VS_in,
  input  logic        BLANK_N_in,
  input  logic [9:0]  sprite_x,
  input  logic [9:0]  sprite_y,
  input  logic        pal_we,
  input  logic [3:0]  pal_idx,
  input  logic [23:0] pal_data,
  output logic [16:0] fb_addr,
  input  logic [3:0]  fb_rdata,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N,
  output logic        frame_start,
  output logic [7:0]  frame_count
);

  localparam logic [9:0]  SCREEN_W    = 10'd640;
  localparam logic [9:0]  SCREEN_H    = 10'd480;
  localparam logic [16:0] FB_STRIDE   = 17'd320;
  // Sprite extent at 11 bits so sx+size never wraps past 1023 back to 0.
  localparam logic [10:0] SPRITE_SPAN = 11'(SPRITE_SIZE);

  // ---------------------------------------------------------------------------
  // Coordinate decode (feeds stage 1)
  // ---------------------------------------------------------------------------
  logic        on_screen;
  logic        at_frame_top;
  logic        at_shadow_load;
  logic [16:0] row_base;
  logic [16:0] addr_next;

  assign on_screen      = (DrawX < SCREEN_W) && (DrawY < SCREEN_H);
  assign at_frame_top   = (DrawX == 10'd0) && (DrawY == 10'd0);
  // First line of vertical blanking: the visible frame is finished, so a new
  // sprite position can be latched without tearing the current frame.
  assign at_shadow_load = (DrawX == 10'd0) && (DrawY == SCREEN_H);

  // Frame buffer is half resolution in both axes; row * 320 peaks at 76480,
  // so the whole sum stays within 17 bits.
  assign row_base  = {8'd0, DrawY[9:1]} * FB_STRIDE;
  assign addr_next = on_screen ? (row_base + {8'd0, DrawX[9:1]}) : 17'd0;

  // ---------------------------------------------------------------------------
  // Sprite position shadow registers and hit test
  // ---------------------------------------------------------------------------
  logic [9:0]  sx_sh;
  logic [9:0]  sy_sh;
  logic [10:0] draw_x_ext;
  logic [10:0] draw_y_ext;
  logic [10:0] sx_lo;
  logic [10:0] sy_lo;
  logic [10:0] sx_hi;
  logic [10:0] sy_hi;
  logic        hit_next;

  assign draw_x_ext = {1'b0, DrawX};
  assign draw_y_ext = {1'b0, DrawY};
  assign sx_lo      = {1'b0, sx_sh};
  assign sy_lo      = {1'b0, sy_sh};
  assign sx_hi      = sx_lo + SPRITE_SPAN;
  assign sy_hi      = sy_lo + SPRITE_SPAN;

  assign hit_next = (draw_x_ext >= sx_lo) && (draw_x_ext < sx_hi) &&
                    (draw_y_ext >= sy_lo) && (draw_y_ext < sy_hi);

  always_ff @(posedge VGA_CLK) begin
    if (Reset) begin
      sx_sh <= 10'd0;
      sy_sh <= 10'd0;
    end else if (at_shadow_load) begin
      sx_sh <= sprite_x;
      sy_sh <= sprite_y;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: frame-buffer address, sprite hit, syncs
  // ---------------------------------------------------------------------------
  logic s1_hs;
  logic s1_vs;
  logic s1_blank_n;
  logic s1_hit;

  always_ff @(posedge VGA_CLK) begin
    if (Reset) begin
      fb_addr    <= 17'd0;
      s1_hs      <= 1'b0;
      s1_vs      <= 1'b0;
      s1_blank_n <= 1'b0;
      s1_hit     <= 1'b0;
    end else begin
      fb_addr    <= addr_next;
      s1_hs      <= HS_in;
      s1_vs      <= VS_in;
      s1_blank_n <= BLANK_N_in;
      s1_hit     <= hit_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: capture the pixel index returned for fb_addr
  // ---------------------------------------------------------------------------
  logic       s2_hs;
  logic       s2_vs;
  logic       s2_blank_n;
  logic       s2_hit;
  logic [3:0] s2_idx;

  always_ff @(posedge VGA_CLK) begin
    if (Reset) begin
      s2_hs      <= 1'b0;
      s2_vs      <= 1'b0;
      s2_blank_n <= 1'b0;
      s2_hit     <= 1'b0;
      s2_idx     <= 4'd0;
    end else begin
      s2_hs      <= s1_hs;
      s2_vs      <= s1_vs;
      s2_blank_n <= s1_blank_n;
      s2_hit     <= s1_hit;
      s2_idx     <= fb_rdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Palette: 16 x 24-bit registers, gray ramp after reset.
  // Stage 3 reads through the combinational port below; a write on the same
  // edge lands afterwards, so that edge still outputs the old colour.
  // ---------------------------------------------------------------------------
  logic [23:0] palette [16];
  logic [23:0] pal_rgb;

  assign pal_rgb = palette[s2_idx];

  always_ff @(posedge VGA_CLK) begin
    if (Reset) begin
      for (int i = 0; i < 16; i++) begin
        palette[i] <= {3{8'(i * 17)}};
      end
    end else if (pal_we) begin
      palette[pal_idx] <= pal_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: colour select and output syncs
  // ---------------------------------------------------------------------------
  logic [23:0] s3_rgb;

  always_ff @(posedge VGA_CLK) begin
    if (Reset) begin
      s3_rgb      <= 24'd0;
      VGA_HS      <= 1'b0;
      VGA_VS      <= 1'b0;
      VGA_BLANK_N <= 1'b0;
    end else begin
      VGA_HS      <= s2_hs;
      VGA_VS      <= s2_vs;
      VGA_BLANK_N <= s2_blank_n;
      if (!s2_blank_n) begin
        s3_rgb <= 24'd0;
      end else if (s2_hit) begin
        s3_rgb <= SPRITE_COLOR;
      end else begin
        s3_rgb <= pal_rgb;
      end
    end
  end

  assign VGA_R = s3_rgb[23:16];
  assign VGA_G = s3_rgb[15:8];
  assign VGA_B = s3_rgb[7:0];

  // ---------------------------------------------------------------------------
  // Frame marker: the pulse and the count update on the same edge, so
  // frame_count already includes the frame that frame_start announces.
  // ---------------------------------------------------------------------------
  always_ff @(posedge VGA_CLK) begin
    if (Reset) begin
      frame_start <= 1'b0;
      frame_count <= 8'd0;
    end else begin
      frame_start <= at_frame_top;
      if (at_frame_top) begin
        frame_count <= frame_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_color_mapper_pipe.sv
// -----------------------------------------------------------------------------
// Bench for color_mapper_pipe: directed vector tables, hand-written latency,
// palette, sprite, frame-count and reset sequences, then randomized traffic.
// A reference model compares every cycle: it derives each pixel's expected
// colour from the coordinate arithmetic, and a queue delays the expectations by
// the pipeline depth.
// -----------------------------------------------------------------------------
module tb_color_mapper_pipe;

  localparam int          SPRITE_SIZE  = 16;
  localparam logic [23:0] SPRITE_COLOR = 24'hFF0000;
  localparam int          FB_WORDS     = 76800;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic        VGA_CLK;
  logic        Reset;
  logic [9:0]  DrawX, DrawY;
  logic        HS_in, VS_in, BLANK_N_in;
  logic [9:0]  sprite_x, sprite_y;
  logic        pal_we;
  logic [3:0]  pal_idx;
  logic [23:0] pal_data;
  logic [16:0] fb_addr;
  logic [3:0]  fb_rdata;
  logic [7:0]  VGA_R, VGA_G, VGA_B;
  logic        VGA_HS, VGA_VS, VGA_BLANK_N;
  logic        frame_start;
  logic [7:0]  frame_count;

  initial begin
    VGA_CLK = 1'b0;
    forever #5 VGA_CLK = ~VGA_CLK;
  end

  color_mapper_pipe #(
    .SPRITE_SIZE (SPRITE_SIZE),
    .SPRITE_COLOR(SPRITE_COLOR)
  ) dut (
    .VGA_CLK    (VGA_CLK),
    .Reset      (Reset),
    .DrawX      (DrawX),
    .DrawY      (DrawY),
    .HS_in      (HS_in),
    .VS_in      (VS_in),
    .BLANK_N_in (BLANK_N_in),
    .sprite_x   (sprite_x),
    .sprite_y   (sprite_y),
    .pal_we     (pal_we),
    .pal_idx    (pal_idx),
    .pal_data   (pal_data),
    .fb_addr    (fb_addr),
    .fb_rdata   (fb_rdata),
    .VGA_R      (VGA_R),
    .VGA_G      (VGA_G),
    .VGA_B      (VGA_B),
    .VGA_HS     (VGA_HS),
    .VGA_VS     (VGA_VS),
    .VGA_BLANK_N(VGA_BLANK_N),
    .frame_start(frame_start),
    .frame_count(frame_count)
  );

  // Frame-buffer memory: data for the registered address is returned in the
  // same cycle, so it is sampled on the following edge.
  logic [3:0] fb_mem [FB_WORDS];
  assign fb_rdata = (int'(fb_addr) < FB_WORDS) ? fb_mem[fb_addr] : 4'h0;

  // ---------------------------------------------------------------------------
  // Scoreboard bookkeeping
  // ---------------------------------------------------------------------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct {
    logic       hs;
    logic       vs;
    logic       blank_n;
    logic       hit;
    logic [3:0] idx;
  } pix_t;

  pix_t        exp_q[$];
  logic [23:0] pal_m [16];
  int          m_sx, m_sy;
  int          m_frames;
  logic [16:0] exp_addr;
  logic        exp_fs;

  function automatic int spec_addr(input int x, input int y);
    if (x < 640 && y < 480) return (y / 2) * 320 + (x / 2);
    return 0;
  endfunction

  function automatic logic [23:0] gray(input int i);
    logic [7:0] g;
    g = 8'(i * 17);
    return {g, g, g};
  endfunction

  // Called once per clock, just after the edge, while the inputs that edge
  // sampled are still applied.
  task automatic model_step();
    pix_t        p;
    pix_t        cur;
    pix_t        zero;
    logic [23:0] exp_rgb;
    int          x, y, a;
    zero = '{hs: 1'b0, vs: 1'b0, blank_n: 1'b0, hit: 1'b0, idx: 4'd0};
    x = int'(DrawX);
    y = int'(DrawY);
    if (Reset) begin
      exp_q.delete();
      exp_q.push_back(zero);
      exp_q.push_back(zero);
      cur = zero;
      for (int i = 0; i < 16; i++) pal_m[i] = gray(i);
      m_sx = 0;
      m_sy = 0;
      m_frames = 0;
      exp_fs = 1'b0;
      exp_addr = 17'd0;
      exp_rgb = 24'd0;
    end else begin
      a = spec_addr(x, y);
      p.hs      = HS_in;
      p.vs      = VS_in;
      p.blank_n = BLANK_N_in;
      p.hit     = (x >= m_sx) && (x < m_sx + SPRITE_SIZE) &&
                  (y >= m_sy) && (y < m_sy + SPRITE_SIZE);
      p.idx     = fb_mem[a];
      exp_q.push_back(p);
      cur = exp_q.pop_front();
      // Colour uses the palette as it stood before this edge's write.
      if (!cur.blank_n)  exp_rgb = 24'd0;
      else if (cur.hit)  exp_rgb = SPRITE_COLOR;
      else               exp_rgb = pal_m[cur.idx];
      if (pal_we) pal_m[pal_idx] = pal_data;
      if (x == 0 && y == 480) begin
        m_sx = int'(sprite_x);
        m_sy = int'(sprite_y);
      end
      exp_fs = (x == 0 && y == 0);
      if (exp_fs) m_frames = (m_frames + 1) % 256;
      exp_addr = 17'(a);
    end
    check("model_rgb", {8'd0, VGA_R, VGA_G, VGA_B}, {8'd0, exp_rgb});
    check("model_sync", {29'd0, VGA_HS, VGA_VS, VGA_BLANK_N}, {29'd0, cur.hs, cur.vs, cur.blank_n});
    check("model_fb_addr", {15'd0, fb_addr}, {15'd0, exp_addr});
    check("model_frame_start", {31'd0, frame_start}, {31'd0, exp_fs});
    // Count is compared away from the pulse so either update phase is judged
    // only on settled values.
    if (!exp_fs) check("model_frame_count", {24'd0, frame_count}, 32'(m_frames));
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge VGA_CLK);
    #1;
    model_step();
  endtask

  task automatic drive_px(input int x, input int y, input logic blank_n);
    DrawX      = 10'(x);
    DrawY      = 10'(y);
    BLANK_N_in = blank_n;
  endtask

  task automatic drive_random();
    int r;
    Reset  = ($urandom_range(0, 199) == 0);
    HS_in  = 1'($urandom_range(0, 1));
    VS_in  = 1'($urandom_range(0, 1));
    BLANK_N_in = ($urandom_range(0, 7) != 0);
    r = $urandom_range(0, 15);
    if (r == 0) begin
      DrawX = 10'd0;
      DrawY = ($urandom_range(0, 1) == 1) ? 10'd480 : 10'd0;
    end else if (r < 6) begin
      // Land near the current sprite so hits and edges get exercised.
      DrawX = 10'((m_sx + $urandom_range(0, SPRITE_SIZE + 3) + 1022) % 1024);
      DrawY = 10'((m_sy + $urandom_range(0, SPRITE_SIZE + 3) + 1022) % 1024);
    end else begin
      DrawX = 10'($urandom_range(0, 1023));
      DrawY = 10'($urandom_range(0, 600));
    end
    if ($urandom_range(0, 31) == 0) begin
      sprite_x = 10'($urandom_range(0, 1023));
      sprite_y = 10'($urandom_range(0, 520));
    end
    pal_we   = ($urandom_range(0, 7) == 0);
    pal_idx  = 4'($urandom_range(0, 15));
    pal_data = 24'($urandom);
  endtask

  // ---------------------------------------------------------------------------
  // Vector tables
  // ---------------------------------------------------------------------------
  typedef struct {
    int          x;
    int          y;
    logic        blank_n;
    logic [16:0] exp_addr;
    logic [23:0] exp_rgb;
  } vec_t;

  vec_t addr_vecs [11];
  vec_t spr_vecs  [6];
  vec_t edge_vecs [4];
  int   pulses;

  initial begin
    // Frame-buffer contents: word a holds a % 16, with one override.
    for (int a = 0; a < FB_WORDS; a++) fb_mem[a] = 4'(a % 16);
    fb_mem[965] = 4'd15;

    // Address / colour vectors with the sprite parked at (1000,1000).
    addr_vecs[0]  = '{10,   7,    1'b1, 17'd965,   24'hFFFFFF};
    addr_vecs[1]  = '{0,    0,    1'b1, 17'd0,     24'h000000};
    addr_vecs[2]  = '{639,  479,  1'b1, 17'd76799, 24'hFFFFFF};
    addr_vecs[3]  = '{640,  0,    1'b0, 17'd0,     24'h000000};
    addr_vecs[4]  = '{0,    480,  1'b0, 17'd0,     24'h000000};
    addr_vecs[5]  = '{1023, 1023, 1'b0, 17'd0,     24'h000000};
    addr_vecs[6]  = '{2,    2,    1'b1, 17'd321,   24'h111111};
    addr_vecs[7]  = '{100,  200,  1'b1, 17'd32050, 24'h222222};
    addr_vecs[8]  = '{333,  101,  1'b0, 17'd16166, 24'h000000};
    addr_vecs[9]  = '{638,  478,  1'b1, 17'd76799, 24'hFFFFFF};
    addr_vecs[10] = '{21,   3,    1'b1, 17'd330,   24'hAAAAAA};

    // Sprite at (100,50), after the shadow load.
    spr_vecs[0] = '{100, 50, 1'b1, 17'd8050,  24'hFF0000};
    spr_vecs[1] = '{115, 65, 1'b1, 17'd10297, 24'hFF0000};
    spr_vecs[2] = '{116, 50, 1'b1, 17'd8058,  24'hAAAAAA};
    spr_vecs[3] = '{99,  50, 1'b1, 17'd8049,  24'h111111};
    spr_vecs[4] = '{100, 66, 1'b1, 17'd10610, 24'h222222};
    spr_vecs[5] = '{107, 58, 1'b1, 17'd9333,  24'hFF0000};

    // Sprite at (630,5), partly off the right edge.
    edge_vecs[0] = '{635, 10, 1'b1, 17'd1917, 24'hFF0000};
    edge_vecs[1] = '{639, 20, 1'b1, 17'd3519, 24'hFF0000};
    edge_vecs[2] = '{3,   10, 1'b1, 17'd1601, 24'h111111};
    edge_vecs[3] = '{639, 21, 1'b1, 17'd3519, 24'hFFFFFF};

    // ---- reset ----
    Reset = 1'b1;
    drive_px(0, 0, 1'b0);
    HS_in = 1'b0; VS_in = 1'b0;
    sprite_x = 10'd0; sprite_y = 10'd0;
    pal_we = 1'b0; pal_idx = 4'd0; pal_data = 24'd0;
    tick();
    tick();
    check("reset_rgb", {8'd0, VGA_R, VGA_G, VGA_B}, 32'd0);
    check("reset_count", {24'd0, frame_count}, 32'd0);
    Reset = 1'b0;

    // Park the sprite out of the way.
    sprite_x = 10'd1000; sprite_y = 10'd1000;
    drive_px(0, 480, 1'b0);
    tick();

    // ---- address / palette table ----
    for (int i = 0; i < 11; i++) begin
      drive_px(addr_vecs[i].x, addr_vecs[i].y, addr_vecs[i].blank_n);
      tick();
      check("vec_fb_addr", {15'd0, fb_addr}, {15'd0, addr_vecs[i].exp_addr});
      tick();
      tick();
      check("vec_rgb", {8'd0, VGA_R, VGA_G, VGA_B}, {8'd0, addr_vecs[i].exp_rgb});
    end

    // ---- HS latency: toggle seen after the third edge ----
    drive_px(50, 50, 1'b1);
    HS_in = 1'b0;
    tick(); tick(); tick();
    HS_in = 1'b1;
    tick();
    check("hs_edge1", {31'd0, VGA_HS}, 32'd0);
    tick();
    check("hs_edge2", {31'd0, VGA_HS}, 32'd0);
    tick();
    check("hs_edge3", {31'd0, VGA_HS}, 32'd1);
    HS_in = 1'b0;

    // ---- palette write while stage 3 reads the same entry ----
    drive_px(6, 0, 1'b1);
    tick(); tick(); tick();
    check("pal_before", {8'd0, VGA_R, VGA_G, VGA_B}, 32'h333333);
    pal_we = 1'b1; pal_idx = 4'd3; pal_data = 24'h123456;
    tick();
    check("pal_same_edge", {8'd0, VGA_R, VGA_G, VGA_B}, 32'h333333);
    pal_we = 1'b0;
    tick();
    check("pal_after", {8'd0, VGA_R, VGA_G, VGA_B}, 32'h123456);

    // ---- sprite moved mid-frame: not drawn until the shadow load ----
    sprite_x = 10'd100; sprite_y = 10'd50;
    drive_px(105, 55, 1'b1);
    tick(); tick(); tick();
    check("spr_midframe", {8'd0, VGA_R, VGA_G, VGA_B}, 32'h444444);
    drive_px(0, 480, 1'b0);
    tick();
    for (int i = 0; i < 6; i++) begin
      drive_px(spr_vecs[i].x, spr_vecs[i].y, spr_vecs[i].blank_n);
      tick(); tick(); tick();
      check("spr_rgb", {8'd0, VGA_R, VGA_G, VGA_B}, {8'd0, spr_vecs[i].exp_rgb});
    end

    // ---- sprite clipped at the right edge, no wrap to X=0 ----
    sprite_x = 10'd630; sprite_y = 10'd5;
    drive_px(0, 480, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive_px(edge_vecs[i].x, edge_vecs[i].y, edge_vecs[i].blank_n);
      tick(); tick(); tick();
      check("edge_rgb", {8'd0, VGA_R, VGA_G, VGA_B}, {8'd0, edge_vecs[i].exp_rgb});
    end

    // ---- 256 frame markers: count wraps back to 0 ----
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 256; i++) begin
      drive_px(0, 0, 1'b0);
      tick();
      if (frame_start) pulses++;
      drive_px(5, 0, 1'b0);
      tick();
      if (frame_start) pulses++;
      if (i == 254) check("frames_255", {24'd0, frame_count}, 32'd255);
    end
    check("frame_pulses", 32'(pulses), 32'd256);
    check("frames_wrap", {24'd0, frame_count}, 32'd0);

    // ---- reset in the middle of a line ----
    drive_px(200, 100, 1'b1);
    HS_in = 1'b1; VS_in = 1'b1;
    tick(); tick(); tick(); tick();
    Reset = 1'b1;
    tick();
    check("rst_rgb", {8'd0, VGA_R, VGA_G, VGA_B}, 32'd0);
    check("rst_sync", {29'd0, VGA_HS, VGA_VS, VGA_BLANK_N}, 32'd0);
    check("rst_addr", {15'd0, fb_addr}, 32'd0);
    Reset = 1'b0;
    tick();
    check("rst_flush1", {29'd0, VGA_HS, VGA_VS, VGA_BLANK_N}, 32'd0);
    tick();
    check("rst_flush2", {8'd0, VGA_R, VGA_G, VGA_B}, 32'd0);
    tick();
    check("rst_resume_sync", {29'd0, VGA_HS, VGA_VS, VGA_BLANK_N}, 32'd7);
    check("rst_resume_rgb", {8'd0, VGA_R, VGA_G, VGA_B}, 32'h444444);

    // ---- randomized traffic against the model ----
    for (int i = 0; i < 4000; i++) begin
      drive_random();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
